// File: rtl/led_status_tx_pkg.sv
// Shared constants for the status-frame return path, plus the header/payload byte selector.
package led_status_tx_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [47:0]  LED_MAC            = 48'hDAD1D2D3D4D5;
  localparam logic [15:0]  LED_ETH_TYPE       = 16'h88B5;
  localparam int unsigned  STATUS_PAYLOAD_LEN = 46;
  localparam int unsigned  OFF_SEQ            = 14;
  localparam int unsigned  OFF_DISP           = 16;
  localparam int unsigned  OFF_RX             = 20;
  localparam int unsigned  OFF_PAD            = 24;

  // Bytes 0..23 are a straight MSB-first concatenation of the fields; everything beyond is zero.
  function automatic logic [7:0] frame_byte(
    input logic [10:0] idx,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] etype,
    input logic [15:0] seq,
    input logic [31:0] disp,
    input logic [31:0] rx
  );
    logic [191:0] hdr;
    logic [191:0] sh;
    hdr = {dst, src, etype, seq, disp, rx};
    sh  = hdr << {idx[4:0], 3'b000};
    if (idx < 11'(OFF_PAD)) return sh[191:184];
    return '0;
  endfunction

endpackage

// File: rtl/led_status_tx_counter.sv
// Free-running wrapping event counter, one increment per inc pulse.
module led_event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + WIDTH'(inc);
  end

  assign count = cnt;

endmodule

// File: rtl/led_status_tx.sv
// Status frame transmitter: snapshots the event counters and streams a fixed Ethernet frame
// onto the MAC TX AXI-Stream interface.
module led_status_tx
  import led_status_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = LED_MAC,
  parameter logic [15:0] ETH_TYPE    = LED_ETH_TYPE,
  parameter int unsigned PAYLOAD_LEN = STATUS_PAYLOAD_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic        frame_start,
  input  logic        rx_frame,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic [15:0] seq_num
);

  localparam logic [10:0] LAST_IDX = 11'(14 + PAYLOAD_LEN - 1);

  state_t      state;
  logic [10:0] idx;
  logic        pending;
  logic [15:0] snap_seq;
  logic [31:0] snap_disp;
  logic [31:0] snap_rx;
  logic [31:0] disp_cnt;
  logic [31:0] rx_cnt;
  logic [10:0] next_idx;
  logic [7:0]  next_byte;

  led_event_counter #(.WIDTH(32)) u_disp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (frame_start),
    .count (disp_cnt)
  );

  led_event_counter #(.WIDTH(32)) u_rx_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rx_frame),
    .count (rx_cnt)
  );

  always_comb begin
    next_idx  = idx + 11'd1;
    next_byte = frame_byte(next_idx, DST_MAC, SRC_MAC, ETH_TYPE, snap_seq, snap_disp, snap_rx);
  end

  assign m_axis_tuser = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      pending       <= 1'b0;
      snap_seq      <= '0;
      snap_disp     <= '0;
      snap_rx       <= '0;
      seq_num       <= '0;
      busy          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_req || pending) begin
            // Counter values are taken before this edge's increment, so a coincident pulse is excluded.
            snap_seq      <= seq_num + 16'd1;
            snap_disp     <= disp_cnt;
            snap_rx       <= rx_cnt;
            seq_num       <= seq_num + 16'd1;
            pending       <= 1'b0;
            busy          <= 1'b1;
            idx           <= '0;
            m_axis_tdata  <= DST_MAC[47:40];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (tx_req) pending <= 1'b1;
          if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              idx           <= next_idx;
              m_axis_tdata  <= next_byte;
              m_axis_tlast  <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_tx.sv
// Randomized scoreboard bench for led_status_tx with a frame-level reference model.
module tb_led_status_tx;

  localparam int unsigned TOTAL = 60;

  logic        clk;
  logic        rst;
  logic        tx_req;
  logic        frame_start;
  logic        rx_frame;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic [15:0] seq_num;

  led_status_tx dut (
    .clk           (clk),
    .rst           (rst),
    .tx_req        (tx_req),
    .frame_start   (frame_start),
    .rx_frame      (rx_frame),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .seq_num       (seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t       expq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hs_count = 0;
  bit          rand_ready = 0;
  bit          noisy = 0;

  // Reference model state
  bit          m_busy = 0;
  bit          m_pend = 0;
  logic [15:0] m_seq  = '0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_rx   = '0;
  int unsigned m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] s, input logic [31:0] d, input logic [31:0] r);
    logic [7:0] hdr [14];
    logic [7:0] b;
    beat_t      e;
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'hDA, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'h88, 8'hB5};
    for (int i = 0; i < int'(TOTAL); i++) begin
      if (i < 14)       b = hdr[i];
      else if (i < 16)  b = 8'((s >> (8 * (15 - i))) & 16'hFF);
      else if (i < 20)  b = 8'((d >> (8 * (19 - i))) & 32'hFF);
      else if (i < 24)  b = 8'((r >> (8 * (23 - i))) & 32'hFF);
      else              b = 8'h00;
      e.data = b;
      e.last = (i == int'(TOTAL) - 1);
      expq.push_back(e);
    end
  endtask

  // Model: evaluated between edges with the inputs that the next edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_pend = 0; m_seq = '0; m_disp = '0; m_rx = '0; m_left = 0;
      expq.delete();
    end else begin
      check("tvalid", {31'b0, m_axis_tvalid}, {31'b0, m_busy});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("seq_num", {16'b0, seq_num}, {16'b0, m_seq});
      check("tuser", {31'b0, m_axis_tuser}, 32'd0);
      if (m_busy) begin
        if (tx_req) m_pend = 1;
        if (m_axis_tready) begin
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end else if (tx_req || m_pend) begin
        m_seq++;
        push_frame(m_seq, m_disp, m_rx);
        m_pend = 0;
        m_busy = 1;
        m_left = TOTAL;
      end
      if (frame_start) m_disp++;
      if (rx_frame)    m_rx++;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks AXIS hold stability.
  bit         stall = 0;
  logic [7:0] hold_d;
  logic       hold_l;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("hold_data", {24'b0, m_axis_tdata}, {24'b0, hold_d});
        check("hold_last", {31'b0, m_axis_tlast}, {31'b0, hold_l});
      end
      stall = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          if (expq.size() == 0) begin
            check("unexpected_byte", {24'b0, m_axis_tdata}, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            check("tdata", {24'b0, m_axis_tdata}, {24'b0, e.data});
            check("tlast", {31'b0, m_axis_tlast}, {31'b0, e.last});
          end
          hs_count++;
        end else begin
          stall  = 1;
          hold_d = m_axis_tdata;
          hold_l = m_axis_tlast;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
    else            m_axis_tready = 1'b1;
    if (noisy) begin
      frame_start = ($urandom_range(0, 3) == 0);
      rx_frame    = ($urandom_range(0, 3) == 0);
    end else begin
      frame_start = 1'b0;
      rx_frame    = 1'b0;
    end
  endtask

  task automatic pulse_req();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((m_busy || m_pend || expq.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'b0, m_busy || m_pend}, 32'd0);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    rst = 1'b1; tx_req = 1'b0; frame_start = 1'b0; rx_frame = 1'b0; m_axis_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {24'b0, m_axis_tdata}, 32'd0);
    check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_seq", {16'b0, seq_num}, 32'd0);
    rst = 1'b0;
    tick();

    // Plain frame with tready held high
    pulse_req();
    wait_idle();

    // Known counter values, then random pulses while the frame is in flight
    for (int i = 0; i < 5; i++) begin
      frame_start = 1'b1;
      rx_frame    = (i < 3);
      @(posedge clk); #1;
    end
    frame_start = 1'b0; rx_frame = 1'b0;
    noisy = 1;
    pulse_req();
    wait_idle();
    noisy = 0;

    // Random backpressure
    rand_ready = 1;
    pulse_req();
    wait_idle();
    rand_ready = 0;

    // Several requests inside one frame coalesce to one follow-on frame
    pulse_req();
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      repeat (5) tick();
    end
    wait_idle();

    // Mixed random traffic
    rand_ready = 1;
    noisy = 1;
    for (int i = 0; i < 400; i++) begin
      tx_req = ($urandom_range(0, 15) == 0);
      tick();
    end
    tx_req = 1'b0;
    wait_idle();
    rand_ready = 0;
    noisy = 0;

    // Display counter wrap
    force dut.u_disp_cnt.cnt = 32'hFFFF_FFFF;
    m_disp = 32'hFFFF_FFFF;
    frame_start = 1'b1;
    #1 release dut.u_disp_cnt.cnt;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pulse_req();
    wait_idle();

    // Reset in the middle of a frame
    base = hs_count;
    pulse_req();
    for (int i = 0; i < 200 && hs_count < base + 30; i++) tick();
    check("reach_byte30", hs_count - base, 32'd30);
    rst = 1'b1;
    #1;
    check("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("midrst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_seq", {16'b0, seq_num}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pulse_req();
    wait_idle();

    check("queue_empty", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
